apb_coeff_bank: RTL and testbench
=================================

// Module: apb_coeff_bank
// PURPOSE
//  APB4 completer holding double-buffered (shadow/active) coefficient banks for N_CH filter channels.
//  Successor to the fixed-map APB bridge + MPRAM pair: adds parametrised channel count and depth,
//  atomic per-channel commit, wait states, PSLVERR and sticky W1C status.
//  Sits between the APB bridge and the filter array; filters see only active coefficients.
// PARAMETERS
//  ADDR_WIDTH   10  APB word-address width; must hold 0x10 + N_CH*CH_STRIDE
//  DATA_WIDTH   32  PWDATA/PRDATA width
//  COEFF_WIDTH  20  signed coefficient width, <= DATA_WIDTH
//  N_CH         4   channels, 1..DATA_WIDTH
//  TAPS         72  coefficients per channel
//  WAIT_STATES  0   extra ACCESS cycles with PREADY low, 0..15
// PORTS
//  clk          in   1                          clock
//  rst          in   1                          synchronous, active-high reset
//  PSEL         in   1                          completer select
//  PENABLE      in   1                          access phase
//  PWRITE       in   1                          1 = write
//  PADDR        in   ADDR_WIDTH                 word address
//  PWDATA       in   DATA_WIDTH                 write data
//  PREADY       out  1                          transfer complete
//  PRDATA       out  DATA_WIDTH                 read data, valid when PREADY
//  PSLVERR      out  1                          error, valid when PREADY
//  ch_flag_set  in   N_CH                       hw status pulses (overflow/underflow OR'd)
//  ch_en        out  N_CH                       per-channel enable (CTRL reg)
//  coeff_out    out  COEFF_WIDTH x N_CH x TAPS  active coefficients, signed
//  coeff_vld    out  N_CH                       1-cycle pulse: channel's active bank updated
// BEHAVIOUR
//  Reset: PREADY=0, PRDATA=0, PSLVERR=0, ch_en=0, coeff_vld=0, shadow=active=0, status=0, FSM=IDLE.
//  Reset mid-transfer: transfer abandoned; no register changes; the master must restart.
//  Address map (CH_STRIDE = 2**$clog2(TAPS)):
//   0x00 CTRL   RW  bits[N_CH-1:0] -> ch_en
//   0x01 COMMIT WO  bitmask; reads return 0 with PSLVERR=0
//   0x02 STATUS RW1C sticky flags [N_CH-1:0]
//   0x03 INFO   RO  {TAPS[15:0], COEFF_WIDTH[7:0], N_CH[7:0]}; write -> PSLVERR, no effect
//   0x10 + ch*CH_STRIDE + tap  RW shadow coefficient (tap < TAPS)
//   Any other address, or tap >= TAPS -> PSLVERR=1, write ignored, PRDATA=0.
//  FSM: IDLE -(PSEL & !PENABLE)-> SETUP -(PENABLE)-> WAIT (counter=WAIT_STATES)
//   -> ACCESS: PREADY=1 one cycle, side effects commit here -> IDLE, or SETUP if PSEL held w/o PENABLE.
//   WAIT_STATES=0: WAIT skipped; PREADY asserted the first PENABLE cycle (zero-wait APB).
//   PSEL dropped before ACCESS -> IDLE, no side effects.
//  Writes: shadow takes PWDATA[COEFF_WIDTH-1:0]; reads sign-extend to DATA_WIDTH.
//  COMMIT: on ACCESS, for each set bit ch: active[ch] <= shadow[ch] (all taps, one cycle later);
//   coeff_vld[ch] pulses in the same cycle active updates. Bits >= N_CH ignored.
//   Shadow writes never disturb coeff_out until committed; commit of unchanged shadow still pulses.
//  STATUS: status[ch] <= 1 on ch_flag_set[ch]; W1C clears on ACCESS; set wins over simultaneous clear.
//  PRDATA/PSLVERR registered, driven only while PREADY=1, else 0.
// STRUCTURE
//  Package apb_coeff_pkg: apb_state_e {IDLE,SETUP,WAIT,ACCESS}, register offset localparams,
//   addr-decode result typedef {region, ch, tap, err}.
//  Sub-module apb_coeff_decode (combinational PADDR -> region/ch/tap/err); FSM, banks, status in top.
// TESTING
//  T1 reset: write tap (ch1,5)=0x7FFFF, commit 0x2, rst 1 cycle -> all outputs 0, read returns 0.
//  T2 shadow/commit: write ch0 tap3=0xFFFFE, read -> PRDATA=0xFFFFFFFE, coeff_out[0][3]=0 until
//   COMMIT=0x1, then coeff_out[0][3]=-2 and coeff_vld=4'b0001 for exactly one cycle.
//  T3 errors: read 0x05, write INFO, access ch0 tap 72 -> PSLVERR=1, PRDATA=0, no state change.
//  T4 status: pulse ch_flag_set=4'b0100 -> STATUS=0x4; W1C 0x4 same cycle as new set -> stays 0x4;
//   W1C again -> 0x0.
//  T5 wait states: WAIT_STATES=3, write CTRL=0xF -> PREADY rises 3 cycles after PENABLE, ch_en=0xF.
//  T6 back-to-back: 4 consecutive zero-wait writes to ch2 taps 0..3 + COMMIT 0x4 -> all 4 taps
//   active, coeff_vld=4'b0100 once.

Source files
------------

// File: rtl/apb_coeff_pkg.sv
// apb_coeff_pkg: shared types and constants for the APB coefficient bank.
//   apb_state_e  - transfer FSM states
//   region_e     - decoded register region
//   addr_dec_t   - address decode result {region, ch, tap, err}
//   info_word()  - packs the read-only INFO register contents
package apb_coeff_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StAccess
  } apb_state_e;

  localparam int unsigned CtrlOffset   = 'h00;
  localparam int unsigned CommitOffset = 'h01;
  localparam int unsigned StatusOffset = 'h02;
  localparam int unsigned InfoOffset   = 'h03;
  localparam int unsigned CoeffBase    = 'h10;

  // Fixed-width index fields so the decode type does not depend on parameters.
  localparam int unsigned ChIdxW  = 8;
  localparam int unsigned TapIdxW = 16;

  typedef enum logic [2:0] {
    RegCtrl,
    RegCommit,
    RegStatus,
    RegInfo,
    RegCoeff,
    RegNone
  } region_e;

  typedef struct packed {
    region_e              region;
    logic [ChIdxW-1:0]    ch;
    logic [TapIdxW-1:0]   tap;
    logic                 err;
  } addr_dec_t;

  function automatic logic [31:0] info_word(int unsigned taps, int unsigned cw, int unsigned nch);
    return {taps[15:0], cw[7:0], nch[7:0]};
  endfunction

endpackage

// File: rtl/apb_coeff_bank_if.sv
// apb_coeff_bank_if: APB4 signal bundle between bridge (master) and completer (slave).
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : master -> slave
//   PREADY, PRDATA, PSLVERR              : slave -> master
interface apb_coeff_bank_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_coeff_decode.sv
// apb_coeff_decode: combinational word-address decode for the coefficient bank.
//   addr : APB word address
//   dec  : region, channel, tap and error flag (unmapped address or tap >= TAPS)
module apb_coeff_decode
  import apb_coeff_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TAPS       = 72
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output addr_dec_t             dec
);

  localparam int unsigned TapW     = $clog2(TAPS);
  localparam int unsigned ChStride = 2 ** TapW;
  localparam int unsigned CoeffEnd = CoeffBase + N_CH * ChStride;

  logic [31:0] addr_w;
  logic [31:0] off;

  always_comb begin
    addr_w = 32'(addr);
    off    = addr_w - CoeffBase;
    dec    = '{region: RegNone, ch: '0, tap: '0, err: 1'b1};
    if (addr_w == CtrlOffset) begin
      dec.region = RegCtrl;
      dec.err    = 1'b0;
    end else if (addr_w == CommitOffset) begin
      dec.region = RegCommit;
      dec.err    = 1'b0;
    end else if (addr_w == StatusOffset) begin
      dec.region = RegStatus;
      dec.err    = 1'b0;
    end else if (addr_w == InfoOffset) begin
      dec.region = RegInfo;
      dec.err    = 1'b0;
    end else if (addr_w >= CoeffBase && addr_w < CoeffEnd) begin
      // Channels sit on power-of-two strides; the gap above TAPS is unmapped.
      dec.region = RegCoeff;
      dec.ch     = ChIdxW'(off >> TapW);
      dec.tap    = TapIdxW'(off[TapW-1:0]);
      dec.err    = (32'(dec.tap) >= TAPS);
    end
  end

endmodule

// File: rtl/apb_coeff_bank.sv
// apb_coeff_bank: APB4 completer with double-buffered (shadow/active) coefficient banks.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : APB slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA, PREADY/PRDATA/PSLVERR)
//   ch_flag_set  : per-channel status set pulses from the filters
//   ch_en        : per-channel enable from CTRL
//   coeff_out    : active coefficients [ch][tap], signed COEFF_WIDTH
//   coeff_vld    : one-cycle pulse per channel when its active bank is reloaded
module apb_coeff_bank
  import apb_coeff_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TAPS        = 72,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  apb_coeff_bank_if.slave                              bus,
  input  logic [N_CH-1:0]                              ch_flag_set,
  output logic [N_CH-1:0]                              ch_en,
  output logic [N_CH-1:0][TAPS-1:0][COEFF_WIDTH-1:0]   coeff_out,
  output logic [N_CH-1:0]                              coeff_vld
);

  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TapW = $clog2(TAPS);

  apb_state_e            state_q;
  logic [3:0]            cnt_q;
  logic                  pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic [N_CH-1:0]                            ctrl_q, status_q, commit_q, vld_q;
  logic [N_CH-1:0][TAPS-1:0][COEFF_WIDTH-1:0] shadow_q, active_q;

  addr_dec_t dec;

  apb_coeff_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_CH       (N_CH),
    .TAPS       (TAPS)
  ) u_decode (
    .addr (bus.PADDR),
    .dec  (dec)
  );

  logic [ChW-1:0]  ch_idx;
  logic [TapW-1:0] tap_idx;
  logic            xfer_err, setup_seen, go_access, wr_fire;
  logic [N_CH-1:0] status_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic            unused_bits;

  assign ch_idx      = dec.ch[ChW-1:0];
  assign tap_idx     = dec.tap[TapW-1:0];
  assign unused_bits = ^{dec.ch, dec.tap, bus.PWDATA};
  assign xfer_err    = dec.err | ((dec.region == RegInfo) & bus.PWRITE);
  assign setup_seen  = bus.PSEL & ~bus.PENABLE;
  // Side effects land on the clock edge that closes the ACCESS cycle.
  assign wr_fire     = (state_q == StAccess) & bus.PWRITE & ~xfer_err;
  assign status_clr  = (wr_fire && dec.region == RegStatus) ? bus.PWDATA[N_CH-1:0] : '0;

  // PREADY is registered, so the decision to enter ACCESS is made one cycle ahead.
  always_comb begin
    go_access = 1'b0;
    unique case (state_q)
      StIdle, StAccess: go_access = setup_seen && (WAIT_STATES == 0);
      StSetup:          go_access = bus.PSEL && bus.PENABLE && (WAIT_STATES == 1);
      StWait:           go_access = bus.PSEL && (cnt_q == '0);
      default:          go_access = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (dec.region)
      RegCtrl:   rd_data = DATA_WIDTH'(ctrl_q);
      RegStatus: rd_data = DATA_WIDTH'(status_q);
      RegInfo:   rd_data = DATA_WIDTH'(info_word(TAPS, COEFF_WIDTH, N_CH));
      RegCoeff:  if (!dec.err) rd_data = DATA_WIDTH'($signed(shadow_q[ch_idx][tap_idx]));
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      if (go_access) begin
        state_q   <= StAccess;
        pready_q  <= 1'b1;
        pslverr_q <= xfer_err;
        prdata_q  <= (bus.PWRITE || xfer_err) ? '0 : rd_data;
      end else begin
        unique case (state_q)
          StIdle, StAccess: state_q <= setup_seen ? StSetup : StIdle;
          StSetup: begin
            if (!bus.PSEL) begin
              state_q <= StIdle;
            end else if (bus.PENABLE) begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_STATES - 2);
            end
          end
          StWait: begin
            if (!bus.PSEL) state_q <= StIdle;
            else           cnt_q   <= cnt_q - 4'd1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      status_q <= '0;
      commit_q <= '0;
      vld_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      commit_q <= '0;
      vld_q    <= commit_q;
      for (int c = 0; c < int'(N_CH); c++) begin
        if (commit_q[c]) active_q[c] <= shadow_q[c];
      end
      // A set pulse in the same cycle as a W1C keeps the flag.
      status_q <= (status_q & ~status_clr) | ch_flag_set;
      if (wr_fire) begin
        unique case (dec.region)
          RegCtrl:   ctrl_q   <= bus.PWDATA[N_CH-1:0];
          RegCommit: commit_q <= bus.PWDATA[N_CH-1:0];
          RegCoeff:  shadow_q[ch_idx][tap_idx] <= bus.PWDATA[COEFF_WIDTH-1:0];
          default:   ;
        endcase
      end
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PRDATA  = prdata_q;
  assign bus.PSLVERR = pslverr_q;
  assign ch_en       = ctrl_q;
  assign coeff_out   = active_q;
  assign coeff_vld   = vld_q;

endmodule

// File: tb/tb_apb_coeff_bank.sv
// tb_apb_coeff_bank: randomized APB traffic against a register-map reference model.
// Two instances: one zero-wait (main traffic), one with three wait states.
module tb_apb_coeff_bank;

  localparam int AW = 10, DW = 32, CW = 20, NCH = 4, NT = 72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0, use3 = 1'b0;
  logic [AW-1:0]  paddr = '0;
  logic [DW-1:0]  pwdata = '0;
  logic [NCH-1:0] flags0 = '0, flags3 = '0;

  apb_coeff_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_coeff_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  assign bus0.PSEL    = psel & ~use3;
  assign bus0.PENABLE = penable & ~use3;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus3.PSEL    = psel & use3;
  assign bus3.PENABLE = penable & use3;
  assign bus3.PWRITE  = pwrite;
  assign bus3.PADDR   = paddr;
  assign bus3.PWDATA  = pwdata;

  logic [NCH-1:0]                   ch_en0, vld0, ch_en3, vld3;
  logic [NCH-1:0][NT-1:0][CW-1:0]   coeff_out0, coeff_out3;

  apb_coeff_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_CH(NCH), .TAPS(NT), .WAIT_STATES(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .ch_flag_set(flags0),
    .ch_en(ch_en0), .coeff_out(coeff_out0), .coeff_vld(vld0)
  );

  apb_coeff_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_CH(NCH), .TAPS(NT), .WAIT_STATES(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .ch_flag_set(flags3),
    .ch_en(ch_en3), .coeff_out(coeff_out3), .coeff_vld(vld3)
  );

  logic          pready_m, pslverr_m;
  logic [DW-1:0] prdata_m;
  assign pready_m  = use3 ? bus3.PREADY  : bus0.PREADY;
  assign pslverr_m = use3 ? bus3.PSLVERR : bus0.PSLVERR;
  assign prdata_m  = use3 ? bus3.PRDATA  : bus0.PRDATA;

  // Reference model of the zero-wait instance's register file.
  logic [CW-1:0]  shadow_m [NCH][NT];
  logic [CW-1:0]  active_m [NCH][NT];
  logic [NCH-1:0] ctrl_m, status_m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NT; k++) begin
        shadow_m[c][k] = '0;
        active_m[c][k] = '0;
      end
    ctrl_m   = '0;
    status_m = '0;
  endtask

  task automatic model_xfer(input bit wr, input int a, input logic [31:0] d,
                            input logic [NCH-1:0] fl, output logic [31:0] rd,
                            output bit err, output logic [NCH-1:0] cmask);
    int ch, t;
    rd    = '0;
    err   = 1'b0;
    cmask = '0;
    ch    = (a - 16) / 128;
    t     = (a - 16) % 128;
    if (a == 0) begin
      if (wr) ctrl_m = d[NCH-1:0];
      else    rd = 32'(ctrl_m);
    end else if (a == 1) begin
      if (wr) cmask = d[NCH-1:0];
    end else if (a == 2) begin
      if (!wr) rd = 32'(status_m);
    end else if (a == 3) begin
      if (wr) err = 1'b1;
      else    rd = 32'h0048_1404;
    end else if (a >= 16 && a < 16 + NCH * 128 && t < NT) begin
      if (wr) shadow_m[ch][t] = d[CW-1:0];
      else    rd = {{(32-CW){shadow_m[ch][t][CW-1]}}, shadow_m[ch][t]};
    end else begin
      err = 1'b1;
    end
    if (wr && a == 2) status_m = (status_m & ~d[NCH-1:0]) | fl;
    else              status_m = status_m | fl;
    for (int c = 0; c < NCH; c++)
      if (cmask[c])
        for (int k = 0; k < NT; k++) active_m[c][k] = shadow_m[c][k];
  endtask

  function automatic int active_diffs();
    int n = 0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NT; k++)
        if (coeff_out0[c][k] !== active_m[c][k]) n++;
    return n;
  endfunction

  task automatic apb_xfer(input bit sel3, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NCH-1:0] fl,
                          output logic [DW-1:0] rd, output bit err, output int waits);
    @(negedge clk);
    use3 = sel3; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    waits   = 0;
    while (!pready_m && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (!pready_m) check_eq("pready_timeout", 32'(pready_m), 32'd1);
    rd  = prdata_m;
    err = pslverr_m;
    if (!sel3) flags0 = fl;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; flags0 = '0;
  endtask

  task automatic do_xfer(input string tag, input bit wr, input int a, input logic [31:0] d,
                         input logic [NCH-1:0] fl);
    logic [31:0]    rd_exp, rd;
    bit             err_exp, err;
    logic [NCH-1:0] cmask;
    int             waits;
    model_xfer(wr, a, d, fl, rd_exp, err_exp, cmask);
    apb_xfer(1'b0, wr, AW'(a), d, fl, rd, err, waits);
    check_eq({tag, "_prdata"}, rd, rd_exp);
    check_eq({tag, "_pslverr"}, 32'(err), 32'(err_exp));
    check_eq({tag, "_waits"}, 32'(waits), 32'd0);
    if (cmask != '0) begin
      check_eq({tag, "_vld_pre"}, 32'(vld0), 32'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_vld"}, 32'(vld0), 32'(cmask));
      check_eq({tag, "_active"}, 32'(active_diffs()), 32'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_vld_post"}, 32'(vld0), 32'd0);
    end
  endtask

  task automatic pulse_flags(input logic [NCH-1:0] f);
    @(negedge clk);
    flags0 = f;
    @(negedge clk);
    flags0   = '0;
    status_m = status_m | f;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]  rd;
    bit             err;
    int             waits, kind, ch, t, a;
    logic [31:0]    d;
    logic [NCH-1:0] fl;

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_pready", 32'(bus0.PREADY), 32'd0);
    check_eq("rst_prdata", bus0.PRDATA, 32'd0);
    check_eq("rst_pslverr", 32'(bus0.PSLVERR), 32'd0);
    check_eq("rst_ch_en", 32'(ch_en0), 32'd0);
    check_eq("rst_vld", 32'(vld0), 32'd0);
    check_eq("rst_active", 32'(active_diffs()), 32'd0);
    rst = 1'b0;

    // T1: populate, commit, then reset clears everything.
    do_xfer("t1_wr", 1'b1, 16 + 128 + 5, 32'h0007_FFFF, '0);
    do_xfer("t1_commit", 1'b1, 1, 32'h2, '0);
    check_eq("t1_coeff_pre_rst", 32'(coeff_out0[1][5]), 32'h7FFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("t1_coeff_post_rst", 32'(coeff_out0[1][5]), 32'd0);
    check_eq("t1_ch_en_post_rst", 32'(ch_en0), 32'd0);
    do_xfer("t1_rd", 1'b0, 16 + 128 + 5, '0, '0);

    // T2: shadow write is invisible until commit; read sign-extends.
    do_xfer("t2_wr", 1'b1, 16 + 3, 32'h000F_FFFE, '0);
    do_xfer("t2_rd", 1'b0, 16 + 3, '0, '0);
    check_eq("t2_coeff_uncommitted", 32'(coeff_out0[0][3]), 32'd0);
    do_xfer("t2_commit", 1'b1, 1, 32'h1, '0);
    check_eq("t2_coeff_committed", 32'(coeff_out0[0][3]), 32'h000F_FFFE);

    // T3: error responses.
    do_xfer("t3_rd_hole", 1'b0, 5, '0, '0);
    do_xfer("t3_wr_info", 1'b1, 3, 32'hFFFF_FFFF, '0);
    do_xfer("t3_rd_info", 1'b0, 3, '0, '0);
    do_xfer("t3_wr_tap72", 1'b1, 16 + 72, 32'h1234, '0);
    do_xfer("t3_rd_tap72", 1'b0, 16 + 72, '0, '0);
    do_xfer("t3_rd_ctrl", 1'b0, 0, '0, '0);

    // T4: sticky status, set wins over simultaneous W1C.
    pulse_flags(4'b0100);
    do_xfer("t4_rd1", 1'b0, 2, '0, '0);
    do_xfer("t4_w1c_set", 1'b1, 2, 32'h4, 4'b0100);
    do_xfer("t4_rd2", 1'b0, 2, '0, '0);
    do_xfer("t4_w1c", 1'b1, 2, 32'h4, '0);
    do_xfer("t4_rd3", 1'b0, 2, '0, '0);

    // T5: three wait states, then an abandoned transfer.
    apb_xfer(1'b1, 1'b1, AW'(0), 32'hF, '0, rd, err, waits);
    check_eq("t5_waits", 32'(waits), 32'd3);
    check_eq("t5_pslverr", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("t5_ch_en", 32'(ch_en3), 32'hF);
    use3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = '0; pwdata = '0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5_abort_ch_en", 32'(ch_en3), 32'hF);
    apb_xfer(1'b1, 1'b0, AW'(0), '0, '0, rd, err, waits);
    check_eq("t5_rd_ctrl", rd, 32'hF);
    check_eq("t5_rd_waits", 32'(waits), 32'd3);

    // T6: back-to-back writes to ch2 then one commit.
    for (int k = 0; k < 4; k++) do_xfer("t6_wr", 1'b1, 16 + 256 + k, $urandom, '0);
    do_xfer("t6_commit", 1'b1, 1, 32'h4, '0);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      ch   = $urandom_range(0, NCH - 1);
      t    = $urandom_range(0, 79);
      d    = $urandom;
      fl   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      case (kind)
        0, 1: do_xfer("rnd_wcoef", 1'b1, 16 + ch * 128 + t, d, fl);
        2, 3: do_xfer("rnd_rcoef", 1'b0, 16 + ch * 128 + t, '0, fl);
        4:    do_xfer("rnd_ctrl", 1'($urandom_range(0, 1)), 0, d, fl);
        5:    do_xfer("rnd_commit", 1'($urandom_range(0, 1)), 1, d, fl);
        6:    do_xfer("rnd_status", 1'($urandom_range(0, 1)), 2, d, fl);
        7:    do_xfer("rnd_info", 1'($urandom_range(0, 1)), 3, d, fl);
        8: begin
          a = ($urandom_range(0, 1) == 1) ? $urandom_range(4, 15) : $urandom_range(528, 1023);
          do_xfer("rnd_bad", 1'($urandom_range(0, 1)), a, d, fl);
        end
        default: pulse_flags(NCH'($urandom_range(1, 15)));
      endcase
    end

    @(negedge clk);
    check_eq("end_active", 32'(active_diffs()), 32'd0);
    check_eq("end_ch_en", 32'(ch_en0), 32'(ctrl_m));
    do_xfer("end_status", 1'b0, 2, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
